// File: rtl/csr_bank.sv
// csr_bank: parametrised bank of RW / W1C / RO control-status registers behind a valid/ready port
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_*          software request (valid/ready); write, word address, data, byte strobes
//   rsp_*          software response (valid/ready); read data, address error flag
//   hw_set_i       per-bit set pulses for W1C bits
//   hw_val_i       live values shown through RO bits
//   regs_o         current register image (stored RW/W1C bits, RO bits from hw_val_i)
module csr_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW_MASK   = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] W1C_MASK  = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_write_i,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    input  logic [DATA_WIDTH-1:0]          req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        req_strb_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                           rsp_err_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_val_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int FW = NUM_REGS * DATA_WIDTH;
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [FW-1:0] STORE_MASK = RW_MASK | W1C_MASK;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("csr_bank: DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_REGS < 2 || (2 ** ADDR_WIDTH) < NUM_REGS) begin : g_bad_depth
        $error("csr_bank: NUM_REGS must be >= 2 and fit in ADDR_WIDTH");
    end
    if ((RW_MASK & W1C_MASK) != '0) begin : g_bad_mask
        $error("csr_bank: RW_MASK and W1C_MASK overlap");
    end

    typedef enum logic {IDLE, RESP} state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         reg_q, reg_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  accept, addr_ok;
    logic [DATA_WIDTH-1:0] lane_mask, rd_val;
    logic [FW-1:0]         wr_en, wdata_rep, image;

    // RO bits are never stored; they always show the live hardware value.
    assign image       = (reg_q & STORE_MASK) | (hw_val_i & ~STORE_MASK);
    assign regs_o      = image;
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign accept      = req_valid_i && state_q == IDLE;
    assign addr_ok     = 32'(req_addr_i) < NUM_REGS;
    assign wdata_rep   = {NUM_REGS{req_wdata_i}};

    // Address decode: read mux and per-bit write enables (zero for out-of-range addresses).
    always_comb begin
        lane_mask = '0;
        rd_val    = '0;
        wr_en     = '0;
        for (int b = 0; b < NB; b++) lane_mask[b*8 +: 8] = {8{req_strb_i[b]}};
        for (int n = 0; n < NUM_REGS; n++) begin
            if (req_addr_i == ADDR_WIDTH'(n)) begin
                rd_val = image[n*DATA_WIDTH +: DATA_WIDTH];
                wr_en[n*DATA_WIDTH +: DATA_WIDTH] = (accept && req_write_i) ? lane_mask : '0;
            end
        end
    end

    // Next state. The hardware set is applied after the software clear so that set wins;
    // the read path uses the pre-update image so a same-cycle set is not yet visible.
    always_comb begin
        reg_d   = (reg_q & ~(wr_en & RW_MASK)) | (wdata_rep & wr_en & RW_MASK);
        reg_d   = (reg_d & ~(wdata_rep & wr_en & W1C_MASK)) | (hw_set_i & W1C_MASK);
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            state_d = RESP;
            rdata_d = (addr_ok && !req_write_i) ? rd_val : '0;
            err_d   = !addr_ok;
        end else if (state_q == RESP && rsp_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            reg_q   <= RESET_VAL;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank: scoreboard bench for csr_bank against a per-bit behavioural model
module tb_csr_bank;
    localparam int DW = 32;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam int FW = NR * DW;
    localparam logic [FW-1:0] RST_V = {32'hFFFF_0000, 32'hCC00_1234, 32'h0, 32'hA5A5_0000, 32'h0, 32'h0};
    localparam logic [FW-1:0] RW_M  = {32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFFF};
    localparam logic [FW-1:0] W1C_M = {32'h0, 32'h00FF_0000, 32'h0, 32'h0, 32'h0000_00FF, 32'h0};

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [3:0]    req_strb_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [FW-1:0] hw_set_i = '0;
    logic [FW-1:0] hw_val_i = '0;
    logic [FW-1:0] regs_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    csr_bank #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
        .RESET_VAL(RST_V), .RW_MASK(RW_M), .W1C_MASK(W1C_M)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .hw_set_i(hw_set_i), .hw_val_i(hw_val_i), .regs_o(regs_o)
    );

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: each register is a word; each bit behaves per its access kind.
    typedef struct packed {logic [DW-1:0] d; logic e;} exp_t;
    logic [DW-1:0] m [NR];
    bit            busy;
    bit            last_acc;
    exp_t          q[$];

    function automatic int kind(int n, int b);
        return RW_M[n*DW+b] ? 0 : W1C_M[n*DW+b] ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] view(int n);
        logic [DW-1:0] v;
        for (int b = 0; b < DW; b++) v[b] = (kind(n, b) == 2) ? hw_val_i[n*DW+b] : m[n][b];
        return v;
    endfunction

    function automatic logic [FW-1:0] image();
        logic [FW-1:0] img;
        for (int n = 0; n < NR; n++) img[n*DW +: DW] = view(n);
        return img;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        last_acc = 1'b0;
        if (rst_i) begin
            busy = 1'b0;
            q.delete();
            for (int n = 0; n < NR; n++) m[n] = RST_V[n*DW +: DW];
        end else begin
            if (busy) begin
                if (rsp_ready_i) busy = 1'b0;
            end else if (req_valid_i) begin
                last_acc = 1'b1;
                busy = 1'b1;
                if (int'(req_addr_i) >= NR) begin
                    q.push_back(exp_t'{d: DW'(0), e: 1'b1});
                end else begin
                    q.push_back(exp_t'{d: req_write_i ? DW'(0) : view(int'(req_addr_i)), e: 1'b0});
                    if (req_write_i)
                        for (int b = 0; b < DW; b++)
                            if (req_strb_i[b/8]) begin
                                if (kind(int'(req_addr_i), b) == 0) m[req_addr_i][b] = req_wdata_i[b];
                                else if (kind(int'(req_addr_i), b) == 1 && req_wdata_i[b]) m[req_addr_i][b] = 1'b0;
                            end
                end
            end
            for (int n = 0; n < NR; n++)
                for (int b = 0; b < DW; b++)
                    if (kind(n, b) == 1 && hw_set_i[n*DW+b]) m[n][b] = 1'b1;
        end
    end

    // Monitor: handshake status, register image, response stability, scoreboard pop.
    logic          pv, phs, pe, last_err;
    logic [DW-1:0] pd, last_rdata;
    exp_t          mx;

    always @(negedge clk_i) begin
        if (rst_i) begin
            pv = 1'b0;
            phs = 1'b0;
        end else begin
            chk("rsp_valid", FW'(rsp_valid_o), FW'(busy));
            chk("req_ready", FW'(req_ready_o), FW'(!busy));
            chk("regs_o", regs_o, image());
            if (rsp_valid_o && pv && !phs) begin
                chk("hold_rdata", FW'(rsp_rdata_o), FW'(pd));
                chk("hold_err", FW'(rsp_err_o), FW'(pe));
            end
            phs = rsp_valid_o && rsp_ready_i;
            if (phs) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got response %0h, expected none", rsp_rdata_o);
                end else begin
                    mx = q.pop_front();
                    chk("rsp_rdata", FW'(rsp_rdata_o), FW'(mx.d));
                    chk("rsp_err", FW'(rsp_err_o), FW'(mx.e));
                end
                last_rdata = rsp_rdata_o;
                last_err = rsp_err_o;
            end
            pv = rsp_valid_o;
            pd = rsp_rdata_o;
            pe = rsp_err_o;
        end
    end

    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i = a;
        req_wdata_i = d;
        req_strb_i = s;
        for (int i = 0; ; i++) begin
            @(posedge clk_i);
            #2;
            if (last_acc) break;
            if (i > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got no accept, expected accept within 100 cycles");
                break;
            end
        end
        req_valid_i = 1'b0;
        hw_set_i = '0;
        chk("valid_after_accept", FW'(rsp_valid_o), FW'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk_i);
            #2;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got no response handshake, expected one within 100 cycles");
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        access(1'b1, a, d, s);
        wait_done();
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        access(1'b0, a, '0, '0);
        wait_done();
        chk($sformatf("read%0d_data", a), FW'(last_rdata), FW'(d));
        chk($sformatf("read%0d_err", a), FW'(last_err), FW'(e));
    endtask

    task automatic pulse(input int n, input logic [DW-1:0] v);
        hw_set_i[n*DW +: DW] = v;
        @(posedge clk_i);
        #2;
        hw_set_i = '0;
    endtask

    initial begin
        hw_val_i[3*DW +: DW] = 32'hDEAD_BEEF;
        hw_val_i[4*DW +: DW] = 32'h5A00_0000;
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        chk("reset_ready", FW'(req_ready_o), FW'(1));
        chk("reset_valid", FW'(rsp_valid_o), FW'(0));
        chk("reset_rdata", FW'(rsp_rdata_o), FW'(0));
        chk("reset_err", FW'(rsp_err_o), FW'(0));
        @(posedge clk_i);
        #2;
        read_chk(2, 32'hA5A5_0000, 1'b0);
        write(0, 32'h1122_3344, 4'b0101);
        read_chk(0, 32'h0022_0044, 1'b0);
        write(0, 32'hFFFF_FFFF, 4'b0000);
        read_chk(0, 32'h0022_0044, 1'b0);
        pulse(1, 32'h09);
        read_chk(1, 32'h09, 1'b0);
        write(1, 32'h01, 4'hF);
        read_chk(1, 32'h08, 1'b0);
        hw_set_i[1*DW +: DW] = 32'h08;
        write(1, 32'h08, 4'hF);
        read_chk(1, 32'h08, 1'b0);
        hw_set_i[1*DW +: DW] = 32'h20;
        read_chk(1, 32'h08, 1'b0);
        read_chk(1, 32'h28, 1'b0);
        write(3, 32'h0, 4'hF);
        read_chk(3, 32'hDEAD_BEEF, 1'b0);
        read_chk(7, 32'h0, 1'b1);
        write(6, 32'hFFFF_FFFF, 4'hF);
        chk("bad_write_err", FW'(last_err), FW'(1));
        read_chk(4, 32'h5A00_1234, 1'b0);

        rsp_ready_i = 1'b0;
        access(1'b0, 2, '0, '0);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i = 5;
        req_wdata_i = 32'h1234_5678;
        req_strb_i = 4'hF;
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_valid", FW'(rsp_valid_o), FW'(1));
            chk("bp_ready", FW'(req_ready_o), FW'(0));
            chk("bp_rdata", FW'(rsp_rdata_o), FW'(32'hA5A5_0000));
        end
        @(posedge clk_i);
        #2;
        rsp_ready_i = 1'b1;
        write(5, 32'h1234_5678, 4'hF);
        read_chk(5, 32'h1234_5678, 1'b0);

        for (int it = 0; it < 600; it++) begin
            @(posedge clk_i);
            #2;
            if (last_acc) req_valid_i = 1'b0;
            if (!req_valid_i && $urandom_range(1, 0) == 1) begin
                req_valid_i = 1'b1;
                req_write_i = $urandom_range(1, 0) == 1;
                req_addr_i = AW'($urandom_range(7, 0));
                req_wdata_i = $urandom();
                req_strb_i = 4'($urandom_range(15, 0));
            end
            rsp_ready_i = $urandom_range(3, 0) != 0;
            for (int n = 0; n < NR; n++) begin
                hw_set_i[n*DW +: DW] = $urandom() & $urandom() & $urandom();
                if ($urandom_range(7, 0) == 0) hw_val_i[n*DW +: DW] = $urandom();
            end
        end
        @(posedge clk_i);
        #2;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        hw_set_i = '0;
        wait_done();

        hw_val_i[4*DW +: DW] = 32'h5A00_0000;
        rsp_ready_i = 1'b0;
        access(1'b0, 0, '0, '0);
        rst_i = 1'b1;
        #1;
        chk("rst_resp_valid", FW'(rsp_valid_o), FW'(0));
        chk("rst_resp_ready", FW'(req_ready_o), FW'(1));
        chk("rst_resp_regs", regs_o & (RW_M | W1C_M), RST_V & (RW_M | W1C_M));
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        read_chk(0, 32'h0, 1'b0);
        read_chk(2, 32'hA5A5_0000, 1'b0);
        read_chk(4, 32'h5A00_1234, 1'b0);
        read_chk(5, 32'hFFFF_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised bank of NUM_REGS control/status registers. DATA_WIDTH must be a multiple of 8.
- Per-bit access types:
  - RW: software read/write.
  - W1C: sticky status, set by hardware, cleared when software writes 1.
  - RO: live hardware value.
- Software access uses a single-outstanding valid/ready request/response port.
- Sits between the controller's management interface and the PHY/LTSSM logic.
- Replaces single-register CSR instances.

Parameters:
- DATA_WIDTH, 32, register width in bits (multiple of 8).
- NUM_REGS, 8, number of registers (≥2).
- ADDR_WIDTH, 3, word-address width; must satisfy 2**ADDR_WIDTH ≥ NUM_REGS.
- RESET_VAL, '0, NUM_REGS*DATA_WIDTH flat reset image; register n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- RW_MASK, '1, flat per-bit mask, 1 = RW bit.
- W1C_MASK, '0, flat per-bit mask, 1 = W1C bit. RW_MASK & W1C_MASK must be 0. Bits in neither mask are RO.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  word address
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  byte-lane write enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err_o  out  1  address ≥ NUM_REGS
- hw_set_i  in  NUM_REGS*DATA_WIDTH  per-bit set pulses for W1C bits
- hw_val_i  in  NUM_REGS*DATA_WIDTH  live values for RO bits
- regs_o  out  NUM_REGS*DATA_WIDTH  current register image (RO bits show hw_val_i)

Behaviour:
- Clock clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - Stored RW/W1C bits take RESET_VAL.
  - FSM goes to IDLE.
  - req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
- FSM states: IDLE and RESP.
  - IDLE: req_ready_o = 1. On valid&ready, move to RESP at the next edge.
  - RESP: req_ready_o = 0, rsp_valid_o = 1. Response fields stay stable until rsp_ready_i = 1, then return to IDLE.
  - Back-to-back accesses: one access per 2 cycles minimum. No combinational ready→valid paths.
- Accept edge, read: rsp_rdata_o captures the composed register value (stored RW/W1C bits, RO bits from hw_val_i). Reads have no side effects.
- Accept edge, write, per bit in an enabled byte lane:
  - RW bit: takes wdata.
  - W1C bit: cleared if wdata = 1.
  - RO bit: write ignored.
  - Write takes effect at the accept edge; visible on regs_o the next cycle.
- Bad address (req_addr_i ≥ NUM_REGS): no state change, rsp_err_o = 1, rsp_rdata_o = 0.
- hw_set_i is evaluated every cycle. A W1C bit with hw_set_i = 1 becomes 1. hw_set_i on RW/RO bits is ignored.
- Simultaneous software W1C clear and hw_set_i on the same bit: set wins, and the bit reads 1 afterwards.
- Read accepted in the same cycle as hw_set_i: the read returns the pre-set value.
- regs_o is combinational from stored bits plus hw_val_i.
- Reset asserted mid-transaction: the response is dropped, the FSM goes to IDLE, and registers return to RESET_VAL.
- req_strb_i = 0 on a write: no change, normal response with rsp_err_o = 0.

Test Plan:
- Reset: RESET_VAL reg2 = 32'hA5A5_0000. After reset, read addr 2 → rsp_rdata_o = 32'hA5A5_0000, err = 0. rsp_valid_o is seen one cycle after accept.
- Byte strobes: reg0 all RW. Write 32'h1122_3344 with strb 4'b0101, then read → 32'h0022_0044 (from reset 0).
- W1C: reg1 W1C_MASK = 32'hFF.
  - Pulse hw_set_i bits 0 and 3, read → 32'h09.
  - Write 32'h01, read → 32'h08.
  - Same-cycle clear of bit 3 with hw_set_i bit 3 → bit 3 reads 1.
- RO/err: reg3 RO with hw_val_i = 32'hDEAD_BEEF.
  - Write 0 to reg3 → read still returns 32'hDEAD_BEEF.
  - Read addr 7 with NUM_REGS = 6 → err = 1, rdata = 0, no state change.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles.
  - rsp_valid_o and rsp_rdata_o stay stable and req_ready_o = 0.
  - A new request presented meanwhile is accepted only after the response handshake.
- Reset in RESP: assert rst_i while rsp_valid_o = 1 → rsp_valid_o = 0 and req_ready_o = 1 immediately; registers equal RESET_VAL.
